alu_pipe: RTL and testbench

- Parametrised, registered successor to the processor's 32-bit combinational ALU.
- Keeps op codes 0-7 with identical meaning, and adds shifts, compares, pass-B and a multi-cycle shift-add multiplier.
- Produces N/Z/C/V flags.
- Talks to the bus-side controller through valid/ready handshakes on both input and output, with one operation in flight at a time.

---
 rtl/alu_pipe.sv | 129 ++++++++++++
 tb/tb_alu_pipe.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes on both sides and a bit-serial
// shift-add multiplier; one operation is in flight at a time.
module alu_pipe #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             busy
);

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // out_valid holds result/flags stable until out_ready is seen.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;
  localparam logic [3:0] OP_MUL  = 4'd13;
  localparam int         MSB     = WIDTH - 1;

  logic [0:0]       state;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] mcand, mplier, acc;
  logic [WIDTH-1:0] mul_sum;
  logic             accept;

  logic [WIDTH-1:0] alu_r;
  logic             alu_c, alu_v;
  logic [WIDTH:0]   sum_w, diff_w, shl_w, shr_w, sra_w;
  logic [SHW-1:0]   shamt;

  assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign shamt    = b[SHW-1:0];
  assign mul_sum  = acc + (mplier[0] ? mcand : '0);

  // The extra bit on each shift captures the last bit shifted out as carry.
  always_comb begin
    sum_w  = {1'b0, a} + {1'b0, b};
    diff_w = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    shl_w  = {1'b0, a} << shamt;
    shr_w  = {a, 1'b0} >> shamt;
    sra_w  = $signed({a, 1'b0}) >>> shamt;
    alu_r  = '0;
    alu_c  = 1'b0;
    alu_v  = 1'b0;
    case (op)
      4'd1:  alu_r = ~a;
      4'd2:  alu_r = a & b;
      4'd3:  alu_r = a | b;
      4'd4:  alu_r = a ^ b;
      4'd5:  alu_r = ~(a ^ b);
      4'd6: begin
        alu_r = sum_w[MSB:0];
        alu_c = sum_w[WIDTH];
        alu_v = (a[MSB] == b[MSB]) && (sum_w[MSB] != a[MSB]);
      end
      4'd7: begin
        alu_r = diff_w[MSB:0];
        alu_c = diff_w[WIDTH];
        alu_v = (a[MSB] != b[MSB]) && (diff_w[MSB] != a[MSB]);
      end
      4'd8:  {alu_c, alu_r} = shl_w;
      4'd9:  {alu_r, alu_c} = shr_w;
      4'd10: {alu_r, alu_c} = sra_w;
      4'd11: alu_r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd12: alu_r = {{(WIDTH-1){1'b0}}, (a < b)};
      4'd14: alu_r = b;
      default: alu_r = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      result    <= '0;
      flags     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      cnt       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (op == OP_MUL) begin
              mcand     <= a;
              mplier    <= b;
              acc       <= '0;
              cnt       <= '0;
              busy      <= 1'b1;
              out_valid <= 1'b0;
              state     <= ST_MUL;
            end else begin
              result    <= alu_r;
              flags     <= {alu_r[MSB], (alu_r == '0), alu_c, alu_v};
              out_valid <= 1'b1;
            end
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          acc    <= mul_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + SHW'(1);
          if (cnt == SHW'(WIDTH - 1)) begin
            result    <= mul_sum;
            flags     <= {mul_sum[MSB], (mul_sum == '0), 2'b00};
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: expected {result,flags} pairs are queued on
// accept and checked by a monitor whenever an output is consumed.
module tb_alu_pipe;

  localparam int W = 32;

  logic          clk, reset;
  logic          in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0]    op, flags;
  logic [W-1:0]  a, b, result;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [W+3:0] exp_q[$];

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags), .busy(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // monitor: an output transfers at the next rising edge
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_output: got result 0x%0h flags %b, expected none", result, flags);
      end else begin
        logic [W+3:0] e;
        e = exp_q.pop_front();
        check("result", result, e[W+3:4]);
        check("flags", flags, e[3:0]);
      end
    end
  end

  // driver: called at posedge+1, returns at posedge+1 after the accept edge
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic push, input logic [W-1:0] er, input logic [3:0] ef);
    int n;
    op = o; a = x; b = y; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      total_cnt++;
      $display("FAIL accept_timeout: got in_ready 0, expected 1 for op %0d", o);
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (push) exp_q.push_back({er, ef});
    end
  endtask

  // counts edges after a MUL accept until out_valid; optionally pokes in_valid
  task automatic mul_wait(input string name, input logic poke);
    int n, bad;
    n = 0; bad = 0;
    while (!out_valid && n < 100) begin
      if (!busy || in_ready) bad++;
      if (poke) begin
        in_valid = (n >= 3 && n <= 5);
        op = 4'd6; a = 1; b = 1;
      end
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    check({name, "_latency"}, n, W);
    check({name, "_busy_stall_bad_cycles"}, bad, 0);
    check({name, "_busy_done"}, busy, 1'b0);
  endtask

  initial begin
    int bad;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
    #12;
    check("reset_result", result, 0);
    check("reset_flags", flags, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check("idle_in_ready", in_ready, 1);

    // ADD overflow with 1-cycle latency check
    issue(4'd6, 32'h7FFF_FFFF, 32'd1, 1, 32'h8000_0000, 4'b1001);
    check("add_latency_out_valid", out_valid, 1);
    issue(4'd6, 32'hFFFF_FFFF, 32'd1, 1, 32'h0000_0000, 4'b0110);
    issue(4'd7, 32'd5, 32'd5, 1, 32'h0, 4'b0110);
    issue(4'd7, 32'd3, 32'd5, 1, 32'hFFFF_FFFE, 4'b1000);
    issue(4'd11, 32'hFFFF_FFFF, 32'd1, 1, 32'd1, 4'b0000);
    issue(4'd12, 32'hFFFF_FFFF, 32'd1, 1, 32'd0, 4'b0100);
    issue(4'd10, 32'h8000_0000, 32'h24, 1, 32'hF800_0000, 4'b1000);
    issue(4'd8, 32'h8000_0001, 32'd1, 1, 32'h0000_0002, 4'b0010);
    issue(4'd9, 32'h1234_5678, 32'h20, 1, 32'h1234_5678, 4'b0000);
    issue(4'd9, 32'h0000_0003, 32'd1, 1, 32'h0000_0001, 4'b0010);
    issue(4'd0, 32'h1234_5678, 32'h1, 1, 32'h0, 4'b0100);
    issue(4'd1, 32'h0F0F_0F0F, 32'h0, 1, 32'hF0F0_F0F0, 4'b1000);
    issue(4'd2, 32'hFF00_FF00, 32'h0F0F_0F0F, 1, 32'h0F00_0F00, 4'b0000);
    issue(4'd3, 32'hF000_0000, 32'h0000_000F, 1, 32'hF000_000F, 4'b1000);
    issue(4'd4, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1, 32'h0, 4'b0100);
    issue(4'd5, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1, 32'hFFFF_FFFF, 4'b1000);
    issue(4'd14, 32'hDEAD_BEEF, 32'h0000_1234, 1, 32'h0000_1234, 4'b0000);
    issue(4'd15, 32'hDEAD_BEEF, 32'h0000_1234, 1, 32'h0, 4'b0100);

    // MUL with in_valid pulses that must be ignored
    issue(4'd13, 32'h0001_0003, 32'd5, 1, 32'h0005_000F, 4'b0000);
    mul_wait("mul", 1'b1);
    @(posedge clk); #1;

    // backpressure with an XOR waiting behind a stalled ADD
    out_ready = 1'b0;
    issue(4'd6, 32'd1, 32'd2, 1, 32'd3, 4'b0000);
    op = 4'd4; a = 32'hF0; b = 32'h0F; in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (!out_valid || in_ready || result != 32'd3 || flags != 4'b0000) bad++;
      @(posedge clk); #1;
    end
    check("stall_bad_cycles", bad, 0);
    out_ready = 1'b1;
    #1;
    check("release_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.push_back({32'h0000_00FF, 4'b0000});
    check("xor_out_valid", out_valid, 1);
    check("xor_next_cycle_result", result, 32'h0000_00FF);
    @(posedge clk); #1;

    // reset in the middle of a MUL, then a clean MUL
    issue(4'd13, 32'h1234_5678, 32'd3, 0, '0, '0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
    end
    check("mid_mul_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_result", result, 0);
    check("async_reset_flags", flags, 0);
    check("async_reset_out_valid", out_valid, 0);
    check("async_reset_busy", busy, 0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check("post_reset_in_ready", in_ready, 1);
    issue(4'd13, 32'd7, 32'd6, 1, 32'd42, 4'b0000);
    mul_wait("mul2", 1'b0);

    bad = 0;
    while (exp_q.size() != 0 && bad < 50) begin
      @(posedge clk); #1;
      bad++;
    end
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
